sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; successor to the fixed 8-bit x 1024 FIFO.
- Adds generic width and depth, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through read mode.
- Adds a synchronous flush, a fill-level output and sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in the same clock domain: payload buffering, rate smoothing.

---
 rtl/fifo_pkg.sv | 50 +++++
 rtl/fifo_ram_1w1r.sv | 68 ++++++
 rtl/sync_fifo_param.sv | 200 ++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the parametrised FIFO family.
//               - clog2        : constant-evaluable ceil(log2(n))
//               - is_pow2      : power-of-two test used by parameter checks
//               - params_ok    : legality of a DATA_W/DEPTH/threshold/mode set
//               - FIFO_MODE_*  : read-mode selector values for the FWFT param
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Read-mode selector values
  localparam int FIFO_MODE_STD  = 0;  // registered read, one cycle latency
  localparam int FIFO_MODE_FWFT = 1;  // head word shown before it is popped

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Full legality check of a FIFO configuration. Pointers wrap naturally,
  // which is only correct for power-of-two depths; the thresholds must be
  // strictly ordered so almost_empty and almost_full never describe the
  // same fill level.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int ae_level, input int af_level,
                                   input int fwft);
    return (data_w >= 1)
        && (depth >= 4)
        && is_pow2(depth)
        && (ae_level < af_level)
        && (af_level <= depth)
        && ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_1w1r.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram_1w1r
// Description : DATA_W x DEPTH storage array with one write port and one
//               read port. REG_OUT selects the read style:
//                 1 : rdata_o is a register loaded from mem[raddr_i] when
//                     re_i is high, held otherwise, cleared by reset
//                 0 : rdata_o is an asynchronous read of mem[raddr_i]
//               The array itself is never reset.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset (output reg only)
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable (registered mode only)
//               raddr_i  - read address
//               rdata_o  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram_1w1r #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int REG_OUT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage has no reset so it maps onto plain RAM macros / LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_W-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end

      assign rdata_o = rdata_q;
    end else begin : g_async_out
      // Read enable and reset have no role when the output is unregistered.
      logic w_unused_async;
      assign w_unused_async = re_i ^ rst_n;

      assign rdata_o = mem_q[raddr_i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with programmable almost
//               thresholds, standard or first-word-fall-through reads,
//               synchronous flush, fill-level output and sticky error flags.
// Ports       : clk          - clock, all logic on rising edge
//               rst_n        - asynchronous active-low reset
//               flush        - synchronous clear of contents (wins over r/w)
//               wr_en        - write request
//               wr_data      - write data
//               rd_en        - read request
//               rd_data      - read data (registered or fall-through)
//               empty        - no readable word
//               full         - no free entry
//               almost_empty - level <= AE_LEVEL
//               almost_full  - level >= AF_LEVEL
//               level        - occupancy 0..DEPTH
//               overflow     - sticky: write attempted while full
//               underflow    - sticky: read attempted while empty
//               clr_err      - clears overflow/underflow (a new event wins)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int c_ADDR_W = clog2(DEPTH);
  localparam int c_LVL_W  = c_ADDR_W + 1;

  localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_LVL_AF   = c_LVL_W'(AF_LEVEL);
  localparam logic [c_LVL_W-1:0] c_LVL_AE   = c_LVL_W'(AE_LEVEL);

  // --------------------------------------------------------------------------
  // Elaboration-time configuration check
  // --------------------------------------------------------------------------
  generate
    if (!params_ok(DATA_W, DEPTH, AE_LEVEL, AF_LEVEL, FWFT)) begin : g_param_err
      $error("sync_fifo_param: illegal configuration DATA_W=%0d DEPTH=%0d AE_LEVEL=%0d AF_LEVEL=%0d FWFT=%0d",
             DATA_W, DEPTH, AE_LEVEL, AF_LEVEL, FWFT);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]  level_q,  level_d;
  logic                overflow_q,  overflow_d;
  logic                underflow_q, underflow_d;

  logic w_empty;
  logic w_full;
  logic w_wa;
  logic w_ra;
  logic w_mem_we;
  logic w_mem_re;

  // All flags decode the registered level only, so no request input ever
  // reaches a flag combinationally and every level change shows up in all
  // flags together one cycle after the accepting edge.
  assign w_empty = (level_q == '0);
  assign w_full  = (level_q == c_LVL_FULL);

  // Accepts use the pre-edge flags: a read on an empty FIFO is refused even
  // when a write lands in the same cycle, and vice versa when full.
  assign w_wa = wr_en & ~w_full;
  assign w_ra = rd_en & ~w_empty;

  // Flush suppresses both the array write and the output-register load so
  // that neither the storage nor rd_data sees a side effect of a flushed
  // request.
  assign w_mem_we = w_wa & ~flush;
  assign w_mem_re = w_ra & ~flush;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are exactly c_ADDR_W bits, so DEPTH-1 wraps to 0 for free.
      if (w_wa) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_ra) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({w_wa, w_ra})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Sticky error flags: clear first, then let a new event override it so a
  // coincident clear can never hide an error. Flush leaves them alone.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && w_full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && w_empty) begin
      underflow_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  // Standard mode registers the read word on a read accept. Fall-through mode
  // reads the head entry asynchronously; after a pop the incremented rd_ptr
  // presents the next word in the following cycle.
  fifo_ram_1w1r #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (c_ADDR_W),
    .REG_OUT ((FWFT == FIFO_MODE_STD) ? 1 : 0)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (w_mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (w_mem_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (level_q <= c_LVL_AE);
  assign almost_full  = (level_q >= c_LVL_AF);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param, DATA_W=8, DEPTH=16,
//               AF_LEVEL=12, AE_LEVEL=2. One instance in standard read mode,
//               one in first-word-fall-through mode. A reference occupancy
//               model and a data queue supply every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n;

  // standard-mode DUT signals
  logic          flush, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]    level;

  // fall-through DUT signals
  logic          f_flush, f_wr_en, f_rd_en, f_clr_err;
  logic [DW-1:0] f_wr_data;
  logic [DW-1:0] f_rd_data;
  logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [4:0]    f_level;

  int checks = 0;
  int errors = 0;

  // reference model of the standard-mode DUT
  logic [DW-1:0] sb [$];
  int            m_level;
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_last  = '0;
  endtask

  // Compare every standard-mode output against the model.
  task automatic check_std(input string tag);
    check({tag, ".level"},     32'(level),        32'(m_level));
    check({tag, ".empty"},     32'(empty),        32'(m_level == 0));
    check({tag, ".full"},      32'(full),         32'(m_level == DP));
    check({tag, ".alm_empty"}, 32'(almost_empty), 32'(m_level <= AE));
    check({tag, ".alm_full"},  32'(almost_full),  32'(m_level >= AF));
    check({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow),    32'(m_udf));
    check({tag, ".rd_data"},   32'(rd_data),      32'(m_last));
  endtask

  // One clock of standard-mode stimulus; the model predicts accepts from
  // its own pre-edge occupancy and the output is compared after the edge.
  task automatic cyc(input string tag, input logic w, input logic [DW-1:0] wd,
                     input logic r, input logic fl, input logic clr);
    logic ewa, era;
    logic [DW-1:0] exp_d;
    ewa   = w && (m_level != DP) && !fl;
    era   = r && (m_level != 0) && !fl;
    exp_d = m_last;
    if (clr) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (w && m_level == DP) m_ovf = 1'b1;
    if (r && m_level == 0)  m_udf = 1'b1;
    if (era) exp_d = sb.pop_front();
    if (ewa) sb.push_back(wd);
    if (fl) begin
      sb.delete();
      m_level = 0;
    end else if (ewa && !era) begin
      m_level++;
    end else if (era && !ewa) begin
      m_level--;
    end
    wr_en = w; wr_data = wd; rd_en = r; flush = fl; clr_err = clr;
    step();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    m_last = exp_d;
    check_std(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
    model_reset();

    // reset state
    @(negedge clk);
    check_std("reset");
    check("reset.f_empty", 32'(f_empty), 32'd1);
    check("reset.f_level", 32'(f_level), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: fill with 0x01..0x10
    for (int i = 1; i <= DP; i++) cyc("fill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);

    // 2: drain in order, then one read too many
    for (int i = 0; i < DP; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc("rd_on_empty", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("rd_on_empty.hold", 32'(rd_data), 32'h10);

    // 3: simultaneous write and read while full
    for (int i = 1; i <= DP; i++) cyc("refill", 1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    cyc("wr_rd_full", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("wr_rd_full.data", 32'(rd_data), 32'h01);
    for (int i = 0; i < DP - 1; i++) cyc("drain_after_ovf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("aa_never_out", 32'(rd_data), 32'h10);

    // 4: level 5 streaming across two pointer wraps
    for (int i = 0; i < 5; i++) cyc("prime5", 1'b1, DW'(8'h61 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc("stream", 1'b1, DW'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("drain5", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 5: first-word-fall-through instance
    f_wr_en = 1'b1; f_wr_data = 8'h5C;
    step();
    f_wr_en = 1'b0;
    check("fwft.empty_after_wr", 32'(f_empty),   32'd0);
    check("fwft.data_no_rd",     32'(f_rd_data), 32'h5C);
    check("fwft.level1",         32'(f_level),   32'd1);
    step();
    check("fwft.data_held",      32'(f_rd_data), 32'h5C);
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    check("fwft.empty_after_rd", 32'(f_empty),   32'd1);
    check("fwft.level0",         32'(f_level),   32'd0);
    check("fwft.no_underflow",   32'(f_udf),     32'd0);
    f_wr_en = 1'b1; f_wr_data = 8'hA1;
    step();
    f_wr_data = 8'hA2;
    step();
    f_wr_en = 1'b0;
    check("fwft.head_a1",        32'(f_rd_data), 32'hA1);
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    check("fwft.head_a2",        32'(f_rd_data), 32'hA2);
    check("fwft.level_after_pop", 32'(f_level),  32'd1);

    // 6: flush with a coincident write, error clear, mid-burst reset
    for (int i = 0; i < 9; i++) cyc("prime9", 1'b1, DW'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    cyc("flush_wr", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    cyc("post_flush_wr", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cyc("post_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flushed_word_absent", 32'(rd_data), 32'h33);
    cyc("clr_err", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc("udf_again", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= DP; i++) cyc("burst", 1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, 1'b0);

    wr_en = 1'b1; wr_data = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    wr_en = 1'b0;
    model_reset();
    check_std("async_reset");
    check("async_reset.f_empty", 32'(f_empty), 32'd1);
    check("async_reset.f_level", 32'(f_level), 32'd0);
    @(negedge clk);
    check_std("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    cyc("after_reset_wr", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    cyc("after_reset_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
